store_merge: RTL and testbench

Store-path narrowing unit for the data-memory port: takes a 32-bit register value plus store size (byte/half/word) and writes only the addressed bytes into a word-only memory. Sub-word stores perform a read-modify-write; word stores write directly. It sits between the MEM-stage store request and the data-memory bus. It is the store-side counterpart of the load-side extension: it narrows 32-bit data into a lane rather than widening a field to 32 bits.

---
 rtl/store_merge.sv | 121 ++++++++++++
 tb/tb_store_merge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// Store narrowing unit: merges a byte/half/word store into the addressed lanes of a word-only memory.
// Word stores write directly; sub-word stores read-modify-write.
module store_merge (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wack,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nx;
  logic [1:0]  lane, lane_nx;
  logic [1:0]  size, size_nx;
  logic [15:0] data, data_nx;
  logic [31:0] addr_nx, wdata_nx, merged;
  logic        done_nx, misalign_nx;
  logic        accept, illegal;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    illegal = 1'b0;
    case (req_size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = req_addr[0];
      SZ_WORD: illegal = |req_addr[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // Only the low half of the store data is kept: word stores bypass it into mem_wdata.
  always_comb begin
    merged = mem_rdata;
    if (size == SZ_HALF) begin
      if (lane[1]) merged[31:16] = data;
      else         merged[15:0]  = data;
    end else begin
      merged[{lane, 3'b000} +: 8] = data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      lane      <= '0;
      size      <= '0;
      data      <= '0;
    end else begin
      state     <= state_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_rd    <= (state_nx == READ);
      mem_wr    <= (state_nx == WRITE);
      done      <= done_nx;
      misalign  <= misalign_nx;
      lane      <= lane_nx;
      size      <= size_nx;
      data      <= data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !illegal) state_nx = (req_size == SZ_WORD) ? WRITE : READ;
      READ:    if (mem_rvalid) state_nx = WRITE;
      WRITE:   if (mem_wack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_nx     = mem_addr;
    wdata_nx    = mem_wdata;
    lane_nx     = lane;
    size_nx     = size;
    data_nx     = data;
    done_nx     = 1'b0;
    misalign_nx = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nx     = {req_addr[31:2], 2'b00};
          lane_nx     = req_addr[1:0];
          size_nx     = req_size;
          data_nx     = req_data[15:0];
          misalign_nx = illegal;
          if (!illegal && req_size == SZ_WORD) wdata_nx = req_data;
        end
      end
      READ:    if (mem_rvalid) wdata_nx = merged;
      WRITE:   done_nx = mem_wack;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_merge.sv
// Bench for store_merge: directed scenarios plus randomized stores against a byte-array memory model.
`timescale 1ns/1ps
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_wack = 1'b0;
  logic        done;
  logic        misalign;

  store_merge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
    .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [31:0] memw [0:63];

  int          o_rd_cnt, o_wr_cnt, o_rd_cyc, o_wr_cyc, o_done_cyc, o_mis_cyc;
  logic [31:0] o_rd_addr, o_wr_addr, o_wdata;
  bit          o_stable, o_both, o_ready;

  function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
    return !((s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00));
  endfunction

  // Memory word viewed as four little-endian bytes; the store overwrites the bytes it covers.
  function automatic logic [31:0] model(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] s);
    logic [7:0] b [4];
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (s == 2'b10) return d;
    if (s == 2'b00) b[k] = d[7:0];
    else begin
      b[k & 2]       = d[7:0];
      b[(k & 2) + 1] = d[15:8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays the memory side, recording what the DUT did cycle by cycle.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int rdly, input int wdly, input bit spur);
    o_rd_cnt = 0; o_wr_cnt = 0; o_rd_cyc = -1; o_wr_cyc = -1; o_done_cyc = -1; o_mis_cyc = -1;
    o_rd_addr = '0; o_wr_addr = '0; o_wdata = '0; o_stable = 1'b1; o_both = 1'b0;
    o_ready = req_ready;
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mem_rd && mem_wr) o_both = 1'b1;
      if (mem_rd) begin
        if (o_rd_cnt == 0) begin o_rd_cyc = cyc; o_rd_addr = mem_addr; end
        else if (mem_addr !== o_rd_addr) o_stable = 1'b0;
        o_rd_cnt++;
      end
      if (mem_wr) begin
        if (o_wr_cnt == 0) begin o_wr_cyc = cyc; o_wr_addr = mem_addr; o_wdata = mem_wdata; end
        else if (mem_addr !== o_wr_addr || mem_wdata !== o_wdata) o_stable = 1'b0;
        o_wr_cnt++;
      end
      if (done && o_done_cyc < 0) o_done_cyc = cyc;
      if (misalign && o_mis_cyc < 0) o_mis_cyc = cyc;
      mem_rvalid = mem_rd && (o_rd_cnt > rdly);
      mem_rdata  = mem_rvalid ? memw[mem_addr[7:2]] : $urandom;
      mem_wack   = mem_wr ? (o_wr_cnt > wdly) : (spur && mem_rd);
      if (mem_wr && mem_wack) memw[mem_addr[7:2]] = mem_wdata;
      if (spur && mem_wr && !mem_wack) mem_rvalid = 1'b1;
      if (done || misalign) break;
      tick();
    end
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", req_ready); end
    tests++; if ({mem_rd, mem_wr, done, misalign} !== 4'b0000) begin fails++;
      $display("FAIL reset_strobes got rd/wr/done/mis=%b want 0000", {mem_rd, mem_wr, done, misalign}); end
    tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++;
      $display("FAIL reset_regs got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
    rst_n = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word();
    run_store(32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 1'b0);
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL word_ready got %b want 1", o_ready); end
    tests++; if (o_wr_cyc !== 1) begin fails++; $display("FAIL word_wr_cycle got %0d want 1", o_wr_cyc); end
    tests++; if (o_done_cyc !== 2) begin fails++; $display("FAIL word_done_cycle got %0d want 2", o_done_cyc); end
    tests++; if (o_rd_cnt !== 0) begin fails++; $display("FAIL word_no_read got %0d rd cycles want 0", o_rd_cnt); end
    tests++; if (o_wr_addr !== 32'h10 || o_wdata !== 32'hDEADBEEF) begin fails++;
      $display("FAIL word_bus got addr=%h wdata=%h want 00000010/deadbeef", o_wr_addr, o_wdata); end
  endtask

  task automatic test_byte();
    memw[4] = 32'h11223344;
    run_store(32'h12, 32'h000000AB, 2'b00, 0, 0, 1'b0);
    tests++; if (o_rd_cyc !== 1 || o_rd_addr !== 32'h10) begin fails++;
      $display("FAIL byte_read got cyc=%0d addr=%h want 1/00000010", o_rd_cyc, o_rd_addr); end
    tests++; if (o_wr_cyc !== 2) begin fails++; $display("FAIL byte_wr_cycle got %0d want 2", o_wr_cyc); end
    tests++; if (o_wdata !== 32'h11AB3344) begin fails++; $display("FAIL byte_wdata got %h want 11ab3344", o_wdata); end
    tests++; if (o_done_cyc !== 3) begin fails++; $display("FAIL byte_done_cycle got %0d want 3", o_done_cyc); end
  endtask

  task automatic test_half();
    memw[1] = 32'h01020304;
    run_store(32'h6, 32'hFFFFCAFE, 2'b01, 0, 0, 1'b0);
    tests++; if (o_wr_addr !== 32'h4 || o_wdata !== 32'hCAFE0304) begin fails++;
      $display("FAIL half_bus got addr=%h wdata=%h want 00000004/cafe0304", o_wr_addr, o_wdata); end
    tests++; if (o_done_cyc !== 3) begin fails++; $display("FAIL half_done_cycle got %0d want 3", o_done_cyc); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h3;  sizes[0] = 2'b01;
    addrs[1] = 32'h2;  sizes[1] = 2'b10;
    addrs[2] = 32'h40; sizes[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      run_store(addrs[i], $urandom, sizes[i], 0, 0, 1'b0);
      tests++; if (o_ready !== 1'b1 || o_mis_cyc !== 1 || o_rd_cnt !== 0 || o_wr_cnt !== 0) begin fails++;
        $display("FAIL misalign_%0d got ready=%b mis_cyc=%0d rd=%0d wr=%0d want 1/1/0/0",
                 i, o_ready, o_mis_cyc, o_rd_cnt, o_wr_cnt); end
    end
    memw[5] = 32'h55667788;
    run_store(32'h15, 32'h0000005A, 2'b00, 0, 0, 1'b0);
    tests++; if (o_ready !== 1'b1 || o_wdata !== 32'h55665A88 || o_done_cyc !== 3) begin fails++;
      $display("FAIL misalign_recover got ready=%b wdata=%h done_cyc=%0d want 1/55665a88/3",
               o_ready, o_wdata, o_done_cyc); end
  endtask

  task automatic test_stall();
    logic [31:0] old, d, exp;
    int extra;
    old = $urandom; d = $urandom;
    memw[9] = old;
    exp = model(old, 32'h26, d, 2'b01);
    run_store(32'h26, d, 2'b01, 3, 2, 1'b1);
    tests++; if (o_stable !== 1'b1 || o_both !== 1'b0) begin fails++;
      $display("FAIL stall_hold got stable=%b overlap=%b want 1/0", o_stable, o_both); end
    tests++; if (o_rd_cnt !== 4 || o_wr_cyc !== 5 || o_wr_cnt !== 3) begin fails++;
      $display("FAIL stall_strobes got rd=%0d wr_cyc=%0d wr=%0d want 4/5/3", o_rd_cnt, o_wr_cyc, o_wr_cnt); end
    tests++; if (o_done_cyc !== 8) begin fails++; $display("FAIL stall_done_cycle got %0d want 8", o_done_cyc); end
    tests++; if (memw[9] !== exp) begin fails++; $display("FAIL stall_mem got %h want %h", memw[9], exp); end
    extra = 0;
    repeat (3) begin tick(); if (done) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL stall_done_once got %0d extra want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc_cnt;
    run_store(32'h80, 32'h12345678, 2'b10, 0, 0, 1'b0);
    run_store(32'h81, 32'h000000C3, 2'b00, 0, 0, 1'b0);
    tests++; if (o_ready !== 1'b1 || o_done_cyc !== 3) begin fails++;
      $display("FAIL b2b_second got ready=%b done_cyc=%0d want 1/3", o_ready, o_done_cyc); end
    run_store(32'h84, 32'h9ABCDEF0, 2'b10, 0, 0, 1'b0);
    tests++; if (cyc_cnt - start !== 7) begin fails++;
      $display("FAIL b2b_throughput got %0d cycles want 7", cyc_cnt - start); end
    tests++; if (memw[32] !== 32'h1234C378) begin fails++; $display("FAIL b2b_mem got %h want 1234c378", memw[32]); end
  endtask

  task automatic test_reset_mid();
    int seen;
    memw[8] = 32'hA5A5A5A5;
    req_valid = 1'b1; req_addr = 32'h21; req_data = 32'h77; req_size = 2'b00;
    tick();
    req_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = memw[8];
    tick();
    mem_rvalid = 1'b0;
    tests++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL rstmid_in_write got wr=%b want 1", mem_wr); end
    rst_n = 1'b0;
    tick();
    tests++; if ({mem_wr, mem_rd, done} !== 3'b000 || req_ready !== 1'b0) begin fails++;
      $display("FAIL rstmid_abort got wr/rd/done=%b ready=%b want 000/0", {mem_wr, mem_rd, done}, req_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
    mem_wack = 1'b1;
    seen = 0;
    repeat (3) begin tick(); if (done) seen++; end
    mem_wack = 1'b0;
    tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_done got %0d done want 0", seen); end
    run_store(32'h21, 32'h00000077, 2'b00, 1, 0, 1'b0);
    tests++; if (o_wdata !== 32'hA5A577A5 || o_done_cyc !== 4) begin fails++;
      $display("FAIL rstmid_next got wdata=%h done_cyc=%0d want a5a577a5/4", o_wdata, o_done_cyc); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, old, exp;
    logic [1:0]  s;
    int rd, wd;
    bit spur;
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 255)); d = $urandom; s = 2'($urandom_range(0, 3));
      rd = $urandom_range(0, 2); wd = $urandom_range(0, 2); spur = 1'($urandom_range(0, 1));
      old = memw[a[7:2]];
      exp = legal(a, s) ? model(old, a, d, s) : old;
      run_store(a, d, s, rd, wd, spur);
      if (legal(a, s)) begin
        tests++; if (o_wdata !== exp || o_wr_addr !== {a[31:2], 2'b00} || !o_stable) begin fails++;
          $display("FAIL rand_%0d_data got wdata=%h addr=%h stable=%b want %h/%h/1",
                   n, o_wdata, o_wr_addr, o_stable, exp, {a[31:2], 2'b00}); end
        tests++; if (o_rd_cnt !== (s == 2'b10 ? 0 : rd + 1) ||
                     o_done_cyc !== (s == 2'b10 ? 2 + wd : 3 + rd + wd)) begin fails++;
          $display("FAIL rand_%0d_timing got rd=%0d done_cyc=%0d want %0d/%0d", n, o_rd_cnt, o_done_cyc,
                   (s == 2'b10 ? 0 : rd + 1), (s == 2'b10 ? 2 + wd : 3 + rd + wd)); end
      end else begin
        tests++; if (o_mis_cyc !== 1 || o_rd_cnt !== 0 || o_wr_cnt !== 0) begin fails++;
          $display("FAIL rand_%0d_misalign got mis_cyc=%0d rd=%0d wr=%0d want 1/0/0",
                   n, o_mis_cyc, o_rd_cnt, o_wr_cnt); end
      end
      tests++; if (memw[a[7:2]] !== exp) begin fails++;
        $display("FAIL rand_%0d_mem got %h want %h", n, memw[a[7:2]], exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memw[i] = $urandom;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
